// File: rtl/button_pulse_gen_if.sv
// button_pulse_gen_if
//   Groups the button-side signals of button_pulse_gen so the conditioner can
//   be dropped between a board pin and a downstream consumer as one bundle.
//   Signals:
//     btn_in     raw button level, asynchronous, active-high, bouncy
//     pulse      one-cycle advance strobe per accepted press (and per repeat)
//     btn_level  debounced button level
//   Modports:
//     master  board/consumer side: drives btn_in, observes pulse and btn_level
//     slave   the conditioner itself: samples btn_in, drives pulse and btn_level
interface button_pulse_gen_if;
   logic btn_in;
   logic pulse;
   logic btn_level;

   modport master (
      output btn_in,
      input  pulse,
      input  btn_level
   );

   modport slave (
      input  btn_in,
      output pulse,
      output btn_level
   );
endinterface

// File: rtl/button_pulse_gen.sv
// button_pulse_gen
//   Turns a raw, asynchronous push-button into a clean single-cycle advance
//   strobe: the button is synchronized, debounced in both directions and
//   edge-detected so exactly one clk-wide pulse is emitted per accepted press.
//   Optional feature (macro AUTO_REPEAT_EN): while the button stays held, extra
//   pulses are emitted after REPEAT_DELAY cycles and then every REPEAT_PERIOD
//   cycles. With the macro undefined no repeat logic is built.
// Ports:
//   clk             system clock
//   rst             synchronous, active-high reset (priority over everything)
//   bus.btn_in      raw button input (slave modport, input)
//   bus.pulse       registered one-cycle strobe (output)
//   bus.btn_level   registered debounced level (output)
// Parameters:
//   SYNC_STAGES      synchronizer depth on btn_in (>= 2)
//   DEBOUNCE_CYCLES  stable cycles required to accept a level change (>= 1)
//   REPEAT_DELAY     held cycles before first auto-repeat pulse (>= 1)
//   REPEAT_PERIOD    cycles between later auto-repeat pulses (>= 1)
module button_pulse_gen #(
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
   parameter int unsigned REPEAT_DELAY    = 50_000_000,
   parameter int unsigned REPEAT_PERIOD   = 10_000_000
) (
   input  logic                 clk,
   input  logic                 rst,
   button_pulse_gen_if.slave    bus
);

   localparam bit CFG_OK = (SYNC_STAGES >= 2) && (DEBOUNCE_CYCLES >= 1) &&
                           (REPEAT_DELAY >= 1) && (REPEAT_PERIOD >= 1);

   if (!CFG_OK) begin : g_bad_cfg
      $error("button_pulse_gen: illegal parameter combination");
   end

   // Debounce counter only ever has to hold DEBOUNCE_CYCLES-1.
   localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      PRESS_WAIT,
      HELD,
      RELEASE_WAIT
   } state_t;

   // ------------------------------------------------------------------
   // Synchronizer
   // ------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], bus.btn_in};
      end
   end

   assign s = sync_q[SYNC_STAGES-1];

   // ------------------------------------------------------------------
   // Debounce FSM
   // ------------------------------------------------------------------
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pulse_q, pulse_d;
   logic             level_q, level_d;

`ifdef AUTO_REPEAT_EN
   localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int unsigned REP_W   = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;
   localparam logic [REP_W-1:0] REP_FIRST = REP_W'(REPEAT_DELAY - 1);
   localparam logic [REP_W-1:0] REP_NEXT  = REP_W'(REPEAT_PERIOD - 1);

   logic [REP_W-1:0] rep_q, rep_d;
   // Set once the first repeat has fired; switches the terminal count from
   // the initial delay to the repeat period.
   logic             rep_run_q, rep_run_d;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         pulse_q   <= 1'b0;
         level_q   <= 1'b0;
`ifdef AUTO_REPEAT_EN
         rep_q     <= '0;
         rep_run_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pulse_q   <= pulse_d;
         level_q   <= level_d;
`ifdef AUTO_REPEAT_EN
         rep_q     <= rep_d;
         rep_run_q <= rep_run_d;
`endif
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pulse_d   = 1'b0;
      level_d   = level_q;
`ifdef AUTO_REPEAT_EN
      // Repeat timer is cleared on every cycle not spent staying in HELD,
      // which also restarts it after a release bounce.
      rep_d     = '0;
      rep_run_d = 1'b0;
`endif

      unique case (state_q)
         IDLE: begin
            if (s) begin
               state_d = PRESS_WAIT;
               cnt_d   = '0;
            end
         end

         PRESS_WAIT: begin
            if (!s) begin
               state_d = IDLE;
            end else if (cnt_q == CNT_LAST) begin
               state_d = HELD;
               pulse_d = 1'b1;
               level_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         HELD: begin
            if (!s) begin
               state_d = RELEASE_WAIT;
               cnt_d   = '0;
            end else begin
`ifdef AUTO_REPEAT_EN
               if (rep_q == (rep_run_q ? REP_NEXT : REP_FIRST)) begin
                  pulse_d   = 1'b1;
                  rep_d     = '0;
                  rep_run_d = 1'b1;
               end else begin
                  rep_d     = rep_q + 1'b1;
                  rep_run_d = rep_run_q;
               end
`endif
            end
         end

         RELEASE_WAIT: begin
            if (s) begin
               state_d = HELD;
            end else if (cnt_q == CNT_LAST) begin
               state_d = IDLE;
               level_d = 1'b0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.pulse     = pulse_q;
   assign bus.btn_level = level_q;

endmodule
